// File: rtl/fp_add_pkg.sv
// fp_add_pkg: shared definitions for the sequenced single-precision adder.
//   - sequencer state enum
//   - default field widths and the internal working-mantissa width
//   - EXP_MAX, the all-ones exponent that encodes infinity
package fp_add_pkg;

   localparam int FP_DATA_W = 32;
   localparam int FP_MENT_W = 23;
   localparam int FP_EXPO_W = 8;
   localparam int FP_SIG_W  = FP_MENT_W + 1;  // stored mantissa + hidden bit
   localparam int FP_INT_W  = FP_MENT_W + 5;  // carry, hidden, mantissa, G, R, S
   localparam int EXP_MAX   = (1 << FP_EXPO_W) - 1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ALIGN,
      ST_ADD,
      ST_NORM,
      ST_ROUND,
      ST_DONE
   } fp_add_state_e;

endpackage

// File: rtl/fp_add_align_shifter.sv
// fp_add_align_shifter: combinational right barrel shifter with sticky collection.
//   data_in   value to shift (significand followed by zeroed G/R/S bits)
//   shamt_in  right-shift amount; any amount >= WIDTH yields just the sticky bit
//   data_out  shifted value, bit 0 ORed with every bit shifted out
module fp_add_align_shifter
   import fp_add_pkg::*;
#(
   parameter int WIDTH = FP_INT_W - 1,
   parameter int SHW   = FP_EXPO_W
) (
   input  logic [WIDTH-1:0] data_in,
   input  logic [SHW-1:0]   shamt_in,
   output logic [WIDTH-1:0] data_out
);

   logic [WIDTH-1:0] lost_mask;

   always_comb begin
      // Oversized shifts give an all-ones mask, so everything folds into sticky.
      lost_mask   = ~({WIDTH{1'b1}} << shamt_in);
      data_out    = data_in >> shamt_in;
      data_out[0] = data_out[0] | (|(data_in & lost_mask));
   end

endmodule

// File: rtl/fp_add_sequencer.sv
// fp_add_sequencer: multi-cycle IEEE-754 single-precision add/subtract.
// Steps one operand pair through ALIGN, ADD, NORM (one bit per cycle) and
// ROUND, then holds the packed result in DONE until the consumer takes it.
// Build option: define FP_ADD_ROUND_NEAREST_EN for round-to-nearest-even;
// otherwise results are truncated (round toward zero). Latency is identical.
// Ports:
//   clk_in, rst_in                    clock, synchronous active-high reset
//   req_valid_in / req_ready_out      request handshake (ready only in IDLE)
//   floating1_in, floating2_in        operands A, B
//   opcode_in                         0 = A+B, 1 = A-B
//   res_valid_out / res_ready_in      response handshake
//   floating_addition_out             packed result, stable while valid
//   busy_out                          an operation is in flight
module fp_add_sequencer
   import fp_add_pkg::*;
#(
   parameter int DATA_WIDTH = FP_DATA_W,
   parameter int MENT_WIDTH = FP_MENT_W,
   parameter int EXPO_WIDTH = FP_EXPO_W
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic                  req_valid_in,
   output logic                  req_ready_out,
   input  logic [DATA_WIDTH-1:0] floating1_in,
   input  logic [DATA_WIDTH-1:0] floating2_in,
   input  logic                  opcode_in,
   output logic                  res_valid_out,
   input  logic                  res_ready_in,
   output logic [DATA_WIDTH-1:0] floating_addition_out,
   output logic                  busy_out
);

   localparam int SIG_W = MENT_WIDTH + 1;
   localparam int INT_W = MENT_WIDTH + 5;
   localparam int ALN_W = INT_W - 1;
   localparam int HID   = INT_W - 2;       // hidden-bit position in man_q
   localparam int XW    = EXPO_WIDTH + 2;  // signed exponent with headroom both ways
   localparam int MAG_W = DATA_WIDTH - 1;

   localparam logic signed [XW-1:0] X_ONE  = XW'(1);
   localparam logic signed [XW-1:0] X_ZERO = '0;
   localparam logic signed [XW-1:0] X_ALL1 = XW'((1 << EXPO_WIDTH) - 1);

   fp_add_state_e         state_q, state_d;
   logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d, result_q, result_d;
   logic                  op_q, op_d, sign_q, sign_d, eff_sub_q, eff_sub_d;
   logic signed [XW-1:0]  exp_q, exp_d;
   logic [INT_W-1:0]      man_q, man_d;
   logic [ALN_W-1:0]      small_q, small_d;

   // ---------------- ALIGN datapath ----------------
   logic                  swap;
   logic [MAG_W-1:0]      lg_mag, sm_mag;
   logic [EXPO_WIDTH-1:0] lg_exp, sm_exp;
   logic [SIG_W-1:0]      lg_sig, sm_sig;
   logic [ALN_W-1:0]      sm_aligned;

   // {exp, mant} compares as magnitude; on a tie A stays the larger.
   assign swap   = b_q[MAG_W-1:0] > a_q[MAG_W-1:0];
   assign lg_mag = swap ? b_q[MAG_W-1:0] : a_q[MAG_W-1:0];
   assign sm_mag = swap ? a_q[MAG_W-1:0] : b_q[MAG_W-1:0];
   assign lg_exp = lg_mag[MAG_W-1 -: EXPO_WIDTH];
   assign sm_exp = sm_mag[MAG_W-1 -: EXPO_WIDTH];
   // exp == 0 is treated as zero: no hidden bit, mantissa dropped.
   assign lg_sig = (lg_exp == '0) ? '0 : {1'b1, lg_mag[MENT_WIDTH-1:0]};
   assign sm_sig = (sm_exp == '0) ? '0 : {1'b1, sm_mag[MENT_WIDTH-1:0]};

   fp_add_align_shifter #(
      .WIDTH (ALN_W),
      .SHW   (EXPO_WIDTH)
   ) u_align_shifter (
      .data_in  ({sm_sig, 3'b000}),
      .shamt_in (lg_exp - sm_exp),
      .data_out (sm_aligned)
   );

   // ---------------- ADD datapath ----------------
   logic [INT_W-1:0] sum;
   // The larger operand is always on the left, so subtraction never goes negative.
   assign sum = eff_sub_q ? (man_q - {1'b0, small_q}) : (man_q + {1'b0, small_q});

   // ---------------- ROUND datapath ----------------
   logic                  rnd_inc;
   logic [SIG_W:0]        rnd_sig;
   logic [MENT_WIDTH-1:0] rnd_man;
   logic signed [XW-1:0]  rnd_exp;

`ifdef FP_ADD_ROUND_NEAREST_EN
   // man_q[3] = LSB, [2] = G, [1] = R, [0] = S
   assign rnd_inc = man_q[2] & (man_q[1] | man_q[0] | man_q[3]);
`else
   assign rnd_inc = 1'b0;
`endif

   assign rnd_sig = {1'b0, man_q[HID:3]} + (SIG_W + 1)'(rnd_inc);
   // Rounding overflow leaves 1.000..: shift right and bump the exponent.
   assign rnd_man = rnd_sig[SIG_W] ? rnd_sig[MENT_WIDTH:1] : rnd_sig[MENT_WIDTH-1:0];
   assign rnd_exp = rnd_sig[SIG_W] ? (exp_q + X_ONE) : exp_q;

   // ---------------- FSM ----------------
   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      b_d       = b_q;
      op_d      = op_q;
      sign_d    = sign_q;
      eff_sub_d = eff_sub_q;
      exp_d     = exp_q;
      man_d     = man_q;
      small_d   = small_q;
      result_d  = result_q;

      case (state_q)
         ST_IDLE: begin
            if (req_valid_in) begin
               a_d     = floating1_in;
               b_d     = floating2_in;
               op_d    = opcode_in;
               state_d = ST_ALIGN;
            end
         end
         ST_ALIGN: begin
            sign_d    = swap ? (b_q[DATA_WIDTH-1] ^ op_q) : a_q[DATA_WIDTH-1];
            eff_sub_d = op_q ^ a_q[DATA_WIDTH-1] ^ b_q[DATA_WIDTH-1];
            exp_d     = {2'b00, lg_exp};
            man_d     = {1'b0, lg_sig, 3'b000};
            small_d   = sm_aligned;
            state_d   = ST_ADD;
         end
         ST_ADD: begin
            if (sum[INT_W-1]) begin
               man_d = {1'b0, sum[INT_W-1:2], sum[1] | sum[0]};
               exp_d = exp_q + X_ONE;
            end else begin
               man_d = sum;
            end
            state_d = ((man_d == '0) || man_d[HID]) ? ST_ROUND : ST_NORM;
         end
         ST_NORM: begin
            // Only reached with a non-zero sum, so the hidden bit always arrives.
            man_d = man_q << 1;
            exp_d = exp_q - X_ONE;
            if (man_d[HID]) state_d = ST_ROUND;
         end
         ST_ROUND: begin
            if (man_q == '0)
               result_d = '0;
            else if (rnd_exp >= X_ALL1)
               result_d = {sign_q, {EXPO_WIDTH{1'b1}}, {MENT_WIDTH{1'b0}}};
            else if (rnd_exp <= X_ZERO)
               result_d = {sign_q, {MAG_W{1'b0}}};
            else
               result_d = {sign_q, rnd_exp[EXPO_WIDTH-1:0], rnd_man};
            state_d = ST_DONE;
         end
         ST_DONE: begin
            if (res_ready_in) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q   <= ST_IDLE;
         a_q       <= '0;
         b_q       <= '0;
         op_q      <= 1'b0;
         sign_q    <= 1'b0;
         eff_sub_q <= 1'b0;
         exp_q     <= '0;
         man_q     <= '0;
         small_q   <= '0;
         result_q  <= '0;
      end else begin
         state_q   <= state_d;
         a_q       <= a_d;
         b_q       <= b_d;
         op_q      <= op_d;
         sign_q    <= sign_d;
         eff_sub_q <= eff_sub_d;
         exp_q     <= exp_d;
         man_q     <= man_d;
         small_q   <= small_d;
         result_q  <= result_d;
      end
   end

   assign req_ready_out         = (state_q == ST_IDLE);
   assign busy_out              = (state_q != ST_IDLE);
   assign res_valid_out         = (state_q == ST_DONE);
   assign floating_addition_out = result_q;

endmodule

// File: tb/tb_fp_add_sequencer.sv
// Bench for fp_add_sequencer. The reference model adds exactly with wide
// integers, then rounds; it follows the build's FP_ADD_ROUND_NEAREST_EN.
// Latency numbers count the accept edge as edge 1.
module tb_fp_add_sequencer;

`ifdef FP_ADD_ROUND_NEAREST_EN
   localparam bit RNE = 1'b1;
`else
   localparam bit RNE = 1'b0;
`endif

   logic        clk_in = 1'b0;
   logic        rst_in = 1'b1;
   logic        req_valid_in = 1'b0;
   logic        req_ready_out;
   logic [31:0] floating1_in = '0;
   logic [31:0] floating2_in = '0;
   logic        opcode_in = 1'b0;
   logic        res_valid_out;
   logic        res_ready_in = 1'b0;
   logic [31:0] floating_addition_out;
   logic        busy_out;

   int checks   = 0;
   int failures = 0;

   fp_add_sequencer dut (
      .clk_in                (clk_in),
      .rst_in                (rst_in),
      .req_valid_in          (req_valid_in),
      .req_ready_out         (req_ready_out),
      .floating1_in          (floating1_in),
      .floating2_in          (floating2_in),
      .opcode_in             (opcode_in),
      .res_valid_out         (res_valid_out),
      .res_ready_in          (res_ready_in),
      .floating_addition_out (floating_addition_out),
      .busy_out              (busy_out)
   );

   always #5 clk_in = ~clk_in;

   // Exact sum on a common scale, then one rounding step.
   function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b,
                                           input logic op);
      logic sa, sb, a_big, sres;
      int ea, eb, el, es, d, dsh, p, eres, sh;
      logic [95:0] xa, xb, xl, xs, mag, sig, rem, half;
      sa = a[31];
      sb = b[31] ^ op;
      ea = int'(a[30:23]);
      eb = int'(b[30:23]);
      xa = (ea == 0) ? 96'd0 : {72'd0, 1'b1, a[22:0]};
      xb = (eb == 0) ? 96'd0 : {72'd0, 1'b1, b[22:0]};
      if (ea == 0) ea = eb;
      if (eb == 0) eb = ea;
      a_big = (ea > eb) || ((ea == eb) && (xa >= xb));
      el = a_big ? ea : eb;
      es = a_big ? eb : ea;
      xl = a_big ? xa : xb;
      xs = a_big ? xb : xa;
      sres = a_big ? sa : sb;
      d = el - es;
      dsh = (d > 60) ? 60 : d;
      xl = xl << dsh;
      if (d > 60) xs = (xs != 0) ? 96'd1 : 96'd0;  // far below half an ulp
      mag = (sa == sb) ? (xl + xs) : (xl - xs);
      if (mag == 0) return 32'h0;
      p = 0;
      for (int i = 0; i < 96; i++) if (mag[i]) p = i;
      eres = el - dsh + p - 23;
      sh = 0;
      rem = '0;
      half = '0;
      if (p >= 23) begin
         sh   = p - 23;
         sig  = mag >> sh;
         rem  = mag & ((96'd1 << sh) - 96'd1);
         if (sh > 0) half = 96'd1 << (sh - 1);
      end else begin
         sig = mag << (23 - p);
      end
      if (RNE && (sh > 0) && ((rem > half) || ((rem == half) && sig[0]))) sig = sig + 96'd1;
      if (sig[24]) begin
         sig  = sig >> 1;
         eres = eres + 1;
      end
      if (eres >= 255) return {sres, 8'hFF, 23'd0};
      if (eres <= 0) return {sres, 31'd0};
      return {sres, eres[7:0], sig[22:0]};
   endfunction

   // Drives one request from an idle DUT, waits for the response, stalls the
   // consumer `stall` cycles, then takes the result. Called at posedge+1.
   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic op,
                         input int stall, output logic [31:0] res, output int lat,
                         output bit tmo, output bit unstable);
      req_valid_in = 1'b1;
      floating1_in = a;
      floating2_in = b;
      opcode_in    = op;
      res_ready_in = 1'b0;
      @(posedge clk_in); #1;
      req_valid_in = 1'b0;
      lat = 1;
      while (!res_valid_out && lat < 60) begin
         // Requests while busy must be ignored.
         req_valid_in = 1'($urandom_range(0, 1));
         floating1_in = $urandom;
         floating2_in = $urandom;
         opcode_in    = 1'($urandom_range(0, 1));
         @(posedge clk_in); #1;
         lat++;
      end
      req_valid_in = 1'b0;
      tmo = !res_valid_out;
      res = floating_addition_out;
      unstable = 1'b0;
      for (int i = 0; i < stall; i++) begin
         @(posedge clk_in); #1;
         if (!res_valid_out || floating_addition_out !== res || req_ready_out) unstable = 1'b1;
      end
      res_ready_in = 1'b1;
      @(posedge clk_in); #1;
      res_ready_in = 1'b0;
   endtask

   task automatic test_reset();
      rst_in       = 1'b1;
      req_valid_in = 1'b1;
      floating1_in = 32'h3F800000;
      floating2_in = 32'h3F800000;
      repeat (3) @(posedge clk_in);
      #1;
      rst_in       = 1'b0;
      req_valid_in = 1'b0;
      checks++; if (req_ready_out !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b want=1", req_ready_out); end
      checks++; if (res_valid_out !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b want=0", res_valid_out); end
      checks++; if (busy_out !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy_out); end
      checks++; if (floating_addition_out !== 32'h0) begin failures++; $display("FAIL reset_out got=%h want=00000000", floating_addition_out); end
   endtask

   task automatic test_directed();
      logic [31:0] ta [6] = '{32'h3F800000, 32'h3FC00000, 32'h3F800000, 32'h7F7FFFFF, 32'hC0000000, 32'h4B800000};
      logic [31:0] tb [6] = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h7F7FFFFF, 32'h40000000, 32'h3FC00000};
      logic        top[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      logic [31:0] texp[6] = '{32'h40000000, 32'h3F000000, 32'h00000000, 32'h7F800000, 32'h00000000,
                               (RNE ? 32'h4B800001 : 32'h4B800000)};
      int          tlat[6] = '{4, 5, 4, 4, 4, 4};
      logic [31:0] res;
      int lat;
      bit tmo, unst;
      for (int i = 0; i < 6; i++) begin
         run_op(ta[i], tb[i], top[i], 0, res, lat, tmo, unst);
         checks++;
         if (tmo || res !== texp[i]) begin
            failures++;
            $display("FAIL directed_%0d result got=%h want=%h timeout=%0b", i, res, texp[i], tmo);
         end
         checks++;
         if (lat != tlat[i]) begin
            failures++;
            $display("FAIL directed_%0d latency got=%0d want=%0d", i, lat, tlat[i]);
         end
      end
   endtask

   task automatic test_random();
      logic [31:0] a, b, res, want;
      logic op;
      int ea, eb, sel, lat, stall;
      bit tmo, unst, eff_add;
      for (int n = 0; n < 150; n++) begin
         a = $urandom;
         ea = $urandom_range(1, 254);
         a[30:23] = 8'(ea);
         b = $urandom;
         sel = $urandom_range(0, 7);
         if (sel == 0) begin
            b[30:0] = a[30:0];                     // cancellation or doubling
         end else if (sel == 1) begin
            b[30:23] = 8'h00;                      // zero operand
         end else if (sel == 2) begin
            b[30:23] = 8'($urandom_range(1, 254)); // any exponent gap
         end else begin
            eb = ea + $urandom_range(0, 64) - 32;
            if (eb < 1) eb = 1;
            if (eb > 254) eb = 254;
            b[30:23] = 8'(eb);
         end
         if ($urandom_range(0, 1) == 1) begin
            res = a; a = b; b = res;               // either operand may be larger
         end
         op = 1'($urandom_range(0, 1));
         stall = $urandom_range(0, 3);
         want = ref_add(a, b, op);
         eff_add = (a[31] == (b[31] ^ op));
         run_op(a, b, op, stall, res, lat, tmo, unst);
         checks++;
         if (tmo || res !== want) begin
            failures++;
            $display("FAIL random_%0d %h %s %h got=%h want=%h timeout=%0b", n, a, op ? "-" : "+", b, res, want, tmo);
         end
         checks++;
         if (eff_add ? (lat != 4) : (lat < 4 || lat > 28)) begin
            failures++;
            $display("FAIL random_%0d latency got=%0d eff_add=%0b", n, lat, eff_add);
         end
         if (stall > 0) begin
            checks++;
            if (unst) begin failures++; $display("FAIL random_%0d hold result/valid changed during stall", n); end
         end
      end
   endtask

   task automatic test_back_to_back();
      int n;
      req_valid_in = 1'b1;
      floating1_in = 32'h3F800000;
      floating2_in = 32'h40000000;
      opcode_in    = 1'b0;
      res_ready_in = 1'b0;
      @(posedge clk_in); #1;
      req_valid_in = 1'b0;
      n = 1;
      while (!res_valid_out && n < 60) begin @(posedge clk_in); #1; n++; end
      checks++; if (!res_valid_out) begin failures++; $display("FAIL bp_first_response got=timeout want=valid"); end
      for (int i = 0; i < 5; i++) begin
         @(posedge clk_in); #1;
         checks++;
         if (res_valid_out !== 1'b1 || req_ready_out !== 1'b0 || busy_out !== 1'b1 || floating_addition_out !== 32'h40400000) begin
            failures++;
            $display("FAIL bp_hold cyc=%0d got valid=%b ready=%b busy=%b out=%h want valid=1 ready=0 busy=1 out=40400000",
                     i, res_valid_out, req_ready_out, busy_out, floating_addition_out);
         end
      end
      res_ready_in = 1'b1;
      @(posedge clk_in); #1;
      res_ready_in = 1'b0;
      checks++;
      if (req_ready_out !== 1'b1 || res_valid_out !== 1'b0) begin
         failures++;
         $display("FAIL bp_release got ready=%b valid=%b want ready=1 valid=0", req_ready_out, res_valid_out);
      end
      req_valid_in = 1'b1;
      floating1_in = 32'h40400000;
      floating2_in = 32'h3F800000;
      opcode_in    = 1'b1;
      @(posedge clk_in); #1;
      req_valid_in = 1'b0;
      checks++;
      if (req_ready_out !== 1'b0 || busy_out !== 1'b1) begin
         failures++;
         $display("FAIL bp_next_accept got ready=%b busy=%b want ready=0 busy=1", req_ready_out, busy_out);
      end
      n = 1;
      while (!res_valid_out && n < 60) begin @(posedge clk_in); #1; n++; end
      checks++;
      if (!res_valid_out || floating_addition_out !== 32'h40000000) begin
         failures++;
         $display("FAIL bp_next_result got=%h valid=%b want=40000000 valid=1", floating_addition_out, res_valid_out);
      end
      res_ready_in = 1'b1;
      @(posedge clk_in); #1;
      res_ready_in = 1'b0;
   endtask

   task automatic test_reset_midop();
      bit saw;
      // 1+ulp minus 1 needs 23 normalization cycles.
      req_valid_in = 1'b1;
      floating1_in = 32'h3F800001;
      floating2_in = 32'h3F800000;
      opcode_in    = 1'b1;
      @(posedge clk_in); #1;
      req_valid_in = 1'b0;
      repeat (3) begin @(posedge clk_in); #1; end
      checks++; if (busy_out !== 1'b1) begin failures++; $display("FAIL midop_busy got=%b want=1", busy_out); end
      rst_in = 1'b1;
      @(posedge clk_in); #1;
      rst_in = 1'b0;
      checks++; if (req_ready_out !== 1'b1) begin failures++; $display("FAIL midop_ready got=%b want=1", req_ready_out); end
      checks++; if (res_valid_out !== 1'b0) begin failures++; $display("FAIL midop_valid got=%b want=0", res_valid_out); end
      checks++; if (floating_addition_out !== 32'h0) begin failures++; $display("FAIL midop_out got=%h want=00000000", floating_addition_out); end
      res_ready_in = 1'b1;
      saw = 1'b0;
      repeat (40) begin
         @(posedge clk_in); #1;
         if (res_valid_out) saw = 1'b1;
      end
      res_ready_in = 1'b0;
      checks++; if (saw) begin failures++; $display("FAIL midop_no_response got=response want=none"); end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_back_to_back();
      test_reset_midop();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
